// File: rtl/tty_uart_tx_pkg.sv
// Shared definitions for the MCU console UART transmitter: character width,
// frame size and the transmit FSM state encodings.
package tty_uart_tx_pkg;

   localparam int TTY_W           = 7;
   localparam int UART_FRAME_BITS = 10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   typedef logic [TTY_W-1:0] tty_char_t;

   // The MCU only emits 7-bit characters; the eighth data bit is always zero.
   function automatic logic [7:0] tty_frame_byte(input tty_char_t ch);
      return {1'b0, ch};
   endfunction

endpackage

// File: rtl/tty_uart_tx_fifo.sv
// Synchronous character FIFO with a separate occupancy counter; pushes while
// full and pops while empty are ignored.
module tty_uart_tx_fifo
   import tty_uart_tx_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_in,
   input  logic          push_i,
   input  tty_char_t     data_i,
   input  logic          pop_i,
   output tty_char_t     data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o
);

   localparam int AW = $clog2(DEPTH);

   tty_char_t     r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;
   logic          w_push;
   logic          w_pop;

   // Full/empty come from the registered level, so a push at a full edge is dropped
   // even when a pop happens on the same edge.
   assign full_o  = (r_level == LW'(DEPTH));
   assign empty_o = (r_level == {LW{1'b0}});
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;
   assign data_o  = r_mem[r_rd_ptr];
   assign level_o = r_level;

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_level  <= {LW{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/tty_uart_tx.sv
// Console UART transmitter: buffers MCU characters and sends them 8N1, LSB first,
// on a flop-driven TX line.
module tty_uart_tx
   import tty_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_in,
   input  logic [TTY_W-1:0]            tty_i,
   input  logic                        tty_we_i,
   output logic                        uart_tx_o,
   output logic                        busy_o,
   output logic                        overflow_o,
   output logic [$clog2(FIFO_DEPTH):0] level_o
);

   localparam int              BW            = $clog2(CLKS_PER_BIT);
   localparam int              LW            = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0]   BAUD_LAST     = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      LAST_DATA_IDX = 3'(UART_FRAME_BITS - 3);

   logic [1:0]    r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_idx;
   logic [7:0]    r_shift;
   logic          r_tx;
   logic          r_active;
   logic          r_overflow;

   tty_char_t     w_head;
   logic          w_full;
   logic          w_empty;
   logic          w_tick;
   logic          w_pop;

   assign w_tick = (r_baud == {BW{1'b0}});
   assign w_pop  = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_tick));

   tty_uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .LW    (LW)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_in  (rst_in),
      .push_i  (tty_we_i),
      .data_i  (tty_i),
      .pop_i   (w_pop),
      .data_o  (w_head),
      .full_o  (w_full),
      .empty_o (w_empty),
      .level_o (level_o)
   );

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= ST_IDLE;
         r_baud  <= {BW{1'b0}};
         r_idx   <= 3'd0;
         r_shift <= 8'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_shift <= tty_frame_byte(w_head);
                  r_baud  <= BAUD_LAST;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               if (w_tick) begin
                  r_baud  <= BAUD_LAST;
                  r_idx   <= 3'd0;
                  r_state <= ST_DATA;
               end else begin
                  r_baud  <= r_baud - BW'(1);
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  r_baud <= BAUD_LAST;
                  if (r_idx == LAST_DATA_IDX) begin
                     r_state <= ST_STOP;
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                  end
               end else begin
                  r_baud <= r_baud - BW'(1);
               end
            end
            ST_STOP: begin
               // Back-to-back frames: the next start bit follows the stop bit with no idle gap.
               if (w_tick) begin
                  r_baud <= BAUD_LAST;
                  if (w_pop) begin
                     r_shift <= tty_frame_byte(w_head);
                     r_state <= ST_START;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_baud <= r_baud - BW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // The line and busy tail lag the FSM by one cycle so every bit lasts exactly CLKS_PER_BIT.
   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         r_tx       <= 1'b1;
         r_active   <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            ST_START: r_tx <= 1'b0;
            ST_DATA:  r_tx <= r_shift[r_idx];
            default:  r_tx <= 1'b1;
         endcase
         r_active   <= (r_state != ST_IDLE);
         r_overflow <= r_overflow | (tty_we_i & w_full);
      end
   end

   assign uart_tx_o  = r_tx;
   assign overflow_o = r_overflow;
   assign busy_o     = (r_state != ST_IDLE) | r_active | ~w_empty;

endmodule

// File: tb/tb_tty_uart_tx.sv
// Scoreboard bench for tty_uart_tx: a transaction-level model predicts accepted
// characters and frame start times; a line monitor decodes frames and compares.
module tb_tty_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk      = 1'b0;
   logic       rst_in   = 1'b0;
   logic [6:0] tty_i    = 7'd0;
   logic       tty_we_i = 1'b0;
   logic       uart_tx_o;
   logic       busy_o;
   logic       overflow_o;
   logic [2:0] level_o;

   always #10 clk = ~clk;

   tty_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk_i      (clk),
      .rst_in     (rst_in),
      .tty_i      (tty_i),
      .tty_we_i   (tty_we_i),
      .uart_tx_o  (uart_tx_o),
      .busy_o     (busy_o),
      .overflow_o (overflow_o),
      .level_o    (level_o)
   );

   typedef struct {
      logic [6:0] ch;
      int         st;
   } exp_t;

   exp_t       expq[$];
   logic [6:0] mq[$];
   int         cyc        = 0;
   int         next_ready = 0;
   int         last_end   = -1;
   bit         m_ovf      = 1'b0;
   int         n_checks   = 0;
   int         n_pass     = 0;

   bit         mon_act = 1'b0;
   bit         mon_have = 1'b0;
   int         t0 = 0;
   logic [7:0] rx = 8'd0;
   exp_t       cur;

   task automatic check_eq(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference model: a character is taken by the transmitter one whole frame after
   // the previous one, or on the edge after it arrives when the line is free.
   initial forever begin
      @(posedge clk or negedge rst_in);
      if (clk) cyc++;
      if (!rst_in) begin
         mq.delete();
         expq.delete();
         next_ready = 0;
         last_end   = -1;
         m_ovf      = 1'b0;
      end else begin
         int pre;
         pre = mq.size();
         if (pre != 0 && cyc >= next_ready) begin
            exp_t e;
            e.ch = mq.pop_front();
            e.st = cyc + 1;
            expq.push_back(e);
            next_ready = cyc + FRAME;
            last_end   = cyc + FRAME;
         end
         if (tty_we_i) begin
            if (pre < DEPTH) mq.push_back(tty_i);
            else m_ovf = 1'b1;
         end
      end
   end

   // Status comparisons every cycle plus serial-line frame monitor.
   initial forever begin
      @(negedge clk);
      if (!rst_in) begin
         mon_act = 1'b0;
      end else begin
         check_eq("level", level_o, mq.size());
         check_eq("overflow", overflow_o, m_ovf);
         check_eq("busy", busy_o, (mq.size() != 0) || (cyc <= last_end));
         if (!mon_act) begin
            if (uart_tx_o === 1'b0) begin
               mon_act  = 1'b1;
               t0       = cyc;
               mon_have = (expq.size() != 0);
               check_eq("frame_expected", mon_have, 1);
               if (mon_have) begin
                  cur = expq.pop_front();
                  check_eq("start_cycle", t0, cur.st);
               end
            end
         end else begin
            int off;
            off = cyc - t0;
            if (off == 2) begin
               check_eq("start_bit", uart_tx_o, 0);
            end else if (off >= 6 && off <= 34 && ((off - 2) % CPB) == 0) begin
               rx[(off - 6) / CPB] = uart_tx_o;
            end else if (off == 38) begin
               check_eq("stop_bit", uart_tx_o, 1);
               if (mon_have) check_eq("frame_data", rx, {1'b0, cur.ch});
               mon_act = 1'b0;
            end
         end
      end
   end

   task automatic wr(input logic [6:0] c);
      tty_i    = c;
      tty_we_i = 1'b1;
      @(negedge clk);
      tty_we_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input int maxc);
      int k;
      k = 0;
      while ((expq.size() != 0 || mq.size() != 0 || mon_act || cyc <= last_end) && k < maxc) begin
         @(negedge clk);
         k++;
      end
      check_eq("drain_within_budget", k < maxc, 1);
      idle(2);
   endtask

   initial begin
      int n0;
      idle(3);
      check_eq("reset_tx", uart_tx_o, 1);
      check_eq("reset_busy", busy_o, 0);
      check_eq("reset_overflow", overflow_o, 0);
      check_eq("reset_level", level_o, 0);
      rst_in = 1'b1;
      idle(5);

      wr(7'h41);
      drain(200);

      wr(7'h48); wr(7'h69); wr(7'h21);
      drain(400);

      for (int i = 0; i < 6; i++) wr(7'(8'h30 + i));
      drain(600);
      check_eq("overflow_sticky", overflow_o, 1);

      // Abort a frame during data bit 3 with another character still queued.
      wr(7'h55);
      n0 = cyc;
      wr(7'h2A);
      while (cyc < n0 + 19) @(negedge clk);
      #5 rst_in = 1'b0;
      #1;
      check_eq("midframe_rst_tx", uart_tx_o, 1);
      check_eq("midframe_rst_level", level_o, 0);
      check_eq("midframe_rst_busy", busy_o, 0);
      check_eq("midframe_rst_overflow", overflow_o, 0);
      idle(3);
      rst_in = 1'b1;
      idle(60);
      wr(7'h7E);
      drain(200);

      // Push and pop on the final stop-bit edge with one character queued.
      wr(7'h11);
      n0 = cyc;
      wr(7'h22);
      while (cyc < n0 + FRAME) @(negedge clk);
      wr(7'h33);
      check_eq("pushpop_level", level_o, 1);
      drain(400);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 24) == 0) begin
            int n;
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) wr(7'($urandom));
         end else begin
            idle(1);
         end
      end
      drain(1000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
